dmem_responder: RTL and testbench

- Data-side responder for the single-cycle CPU's DM_cs/DM_r/DM_w/addr/wdata/rdata bus.
- Serves a word RAM plus a small MMIO page:
  - free-running cycle counter
  - 8-bit console TX FIFO, drained by an external valid/ready sink
  - sticky error register
- Reads are combinational, because the CPU consumes rdata in the same cycle. Writes commit on the clk rising edge.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STAT/ERR bit positions, default address windows.
package dmem_pkg;

  localparam logic [1:0] OFF_CNT  = 2'd0;
  localparam logic [1:0] OFF_TXD  = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_ERR  = 2'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 4;

  localparam int ERR_UNMAPPED = 0;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_OVERFLOW = 2;

  localparam logic [31:0] DEF_RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

  // Occupancy shown in the STAT nibble saturates at 15.
  function automatic logic [3:0] sat_nibble(input int unsigned n);
    logic [31:0] v;
    v = n;
    return (n > 15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy count.
// Head entry is driven from storage and forced to zero while empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push into a full FIFO is only accepted when a pop frees the slot at the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder for the single-cycle CPU: word RAM plus an MMIO page
// with cycle counter, console TX FIFO and sticky W1C error register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_cs,
  input  logic        DM_r,
  input  logic        DM_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cnt_q;
  logic [2:0]    err_q, err_set, err_clr;
  logic          acc, aligned, ram_hit, mmio_hit;
  logic [1:0]    off;
  logic [AW-1:0] ram_idx;
  logic          wr_ok, rd_ok, ram_we, cnt_we, txd_push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  always_comb begin
    acc      = DM_cs && (DM_r || DM_w);
    aligned  = (addr[1:0] == 2'b00);
    ram_hit  = (addr[31:AW+2] == RAM_BASE[31:AW+2]);
    mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
    off      = addr[3:2];
    ram_idx  = addr[AW+1:2];
    wr_ok    = DM_cs && DM_w && aligned;
    rd_ok    = DM_cs && DM_r && aligned;
    ram_we   = wr_ok && ram_hit;
    cnt_we   = wr_ok && !ram_hit && mmio_hit && (off == OFF_CNT);
    txd_push = wr_ok && !ram_hit && mmio_hit && (off == OFF_TXD);
    err_clr  = (wr_ok && !ram_hit && mmio_hit && (off == OFF_ERR)) ? wdata[2:0] : 3'b000;
    err_set  = '0;
    err_set[ERR_MISALIGN] = acc && !aligned;
    err_set[ERR_UNMAPPED] = acc && aligned && !ram_hit && !mmio_hit;
    err_set[ERR_OVERFLOW] = txd_push && fifo_full && !pop;
  end

  // Reads are combinational so the CPU sees them in the same cycle; a same-cycle
  // write to the same location only lands at the edge, so rdata is the old value.
  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      if (ram_hit) begin
        rdata = ram[ram_idx];
      end else if (mmio_hit) begin
        case (off)
          OFF_CNT:  rdata = cnt_q;
          OFF_STAT: begin
            rdata[STAT_EMPTY]          = fifo_empty;
            rdata[STAT_FULL]           = fifo_full;
            rdata[STAT_CNT_LSB +: 4]   = sat_nibble(32'(fifo_count));
          end
          OFF_ERR:  rdata = {29'd0, err_q};
          default:  rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_we ? wdata : cnt_q + 32'd1;
      err_q <= (err_q & ~err_clr) | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= wdata;
  end

  // Console handshake: tx_data/tx_valid hold steady until the sink samples
  // tx_valid && tx_ready high at a clk edge, which consumes the head byte.
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;
  assign pop      = tx_valid && tx_ready;
  assign err      = |err_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (txd_push),
    .pop     (pop),
    .wr_data (wdata[7:0]),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written FIFO/counter/reset
// sequences, then randomized traffic against a queue/array reference model.
module tb_dmem_responder;

  localparam int unsigned RAM_WORDS = 1024;
  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam int          DEPTH     = 8;
  localparam logic [31:0] A_CNT     = MMIO_BASE;
  localparam logic [31:0] A_TXD     = MMIO_BASE + 32'd4;
  localparam logic [31:0] A_STAT    = MMIO_BASE + 32'd8;
  localparam logic [31:0] A_ERR     = MMIO_BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DM_cs = 1'b0, DM_r = 1'b0, DM_w = 1'b0, tx_ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, err;

  int checks = 0;
  int failures = 0;
  bit rdy_lvl = 1'b0;

  // Reference model state
  logic [31:0] ram_m [RAM_WORDS];
  bit          ram_v [RAM_WORDS];
  logic [7:0]  exp_q [$];
  logic [31:0] cnt_m;
  logic [2:0]  err_m;

  typedef struct {
    bit          cs, r, w;
    logic [31:0] a, d;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t vecs[$];

  dmem_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .RAM_BASE   (RAM_BASE),
    .MMIO_BASE  (MMIO_BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .DM_cs    (DM_cs),
    .DM_r     (DM_r),
    .DM_w     (DM_w),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err      (err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= RAM_BASE) && (a < RAM_BASE + 32'(4 * RAM_WORDS));
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= MMIO_BASE) && (a <= MMIO_BASE + 32'd15);
  endfunction

  task automatic model_reset();
    cnt_m = '0;
    err_m = '0;
    exp_q.delete();
  endtask

  task automatic model_rdata(input bit cs, r, input logic [31:0] a,
                             output bit known, output logic [31:0] v);
    int idx, off, n;
    known = 1'b1;
    v = '0;
    if (cs && r && a[1:0] == 2'b00) begin
      if (in_ram(a)) begin
        idx = int'((a - RAM_BASE) >> 2);
        known = ram_v[idx];
        v = ram_m[idx];
      end else if (in_mmio(a)) begin
        off = int'((a - MMIO_BASE) >> 2);
        n = exp_q.size();
        case (off)
          0: v = cnt_m;
          2: v = 32'((n > 15 ? 15 : n) * 16 + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
          3: v = {29'd0, err_m};
          default: v = '0;
        endcase
      end
    end
  endtask

  task automatic model_step(input bit cs, r, w, input logic [31:0] a, d, input bit rdy);
    bit acc, al, hit_r, hit_m, wr;
    logic [2:0] set, clr;
    int off, idx;
    acc   = cs && (r || w);
    al    = (a[1:0] == 2'b00);
    hit_r = in_ram(a);
    hit_m = in_mmio(a);
    off   = int'((a - MMIO_BASE) >> 2);
    wr    = cs && w && al;
    set = '0;
    clr = '0;
    if (acc && !al) set[1] = 1'b1;
    else if (acc && !hit_r && !hit_m) set[0] = 1'b1;
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    if (wr && hit_m && off == 1) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d[7:0]);
      else set[2] = 1'b1;
    end
    if (wr && hit_m && off == 3) clr = d[2:0];
    err_m = (err_m & ~clr) | set;
    cnt_m = (wr && hit_m && off == 0) ? d : cnt_m + 32'd1;
    if (wr && hit_r) begin
      idx = int'((a - RAM_BASE) >> 2);
      ram_m[idx] = d;
      ram_v[idx] = 1'b1;
    end
  endtask

  // Driver: one bus cycle. Entered and left at posedge+1; samples before the edge.
  task automatic cyc(input bit cs, r, w, input logic [31:0] a, d, input bit rdy,
                     output logic [31:0] rd);
    bit known;
    logic [31:0] er;
    logic [31:0] exp_head;
    DM_cs = cs; DM_r = r; DM_w = w; addr = a; wdata = d; tx_ready = rdy;
    #1;
    rd = rdata;
    model_rdata(cs, r, a, known, er);
    if (known) chk("model_rdata", rdata, er);
    exp_head = '0;
    if (exp_q.size() > 0) exp_head = 32'(exp_q[0]);
    chk("model_tx_valid", 32'(tx_valid), 32'(exp_q.size() > 0));
    chk("model_tx_data", 32'(tx_data), exp_head);
    chk("model_err", 32'(err), 32'(err_m != 3'b000));
    @(posedge clk);
    model_step(cs, r, w, a, d, rdy);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, d);
    logic [31:0] dummy;
    cyc(1'b1, 1'b0, 1'b1, a, d, rdy_lvl, dummy);
  endtask

  task automatic idle();
    logic [31:0] dummy;
    cyc(1'b0, 1'b0, 1'b0, '0, '0, rdy_lvl, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cyc(1'b1, 1'b1, 1'b0, a, '0, rdy_lvl, v);
    chk(name, v, exp);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  drain_exp [8];

    // Reset block
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    reset = 1'b1;

    // Counter: five edges after release, then load and wrap
    repeat (5) idle();
    rd_chk("cnt_after_5", A_CNT, 32'd5);
    wr(A_CNT, 32'hFFFF_FFFE);
    rd_chk("cnt_loaded", A_CNT, 32'hFFFF_FFFE);
    rd_chk("cnt_plus1", A_CNT, 32'hFFFF_FFFF);
    rd_chk("cnt_wrap", A_CNT, 32'h0000_0000);

    // Vector table: RAM, decode errors, W1C
    vecs.push_back('{1, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 0, 32'h0, 0});
    vecs.push_back('{1, 1, 0, 32'h1001_0004, 32'h0,         1, 32'hDEAD_BEEF, 0});
    vecs.push_back('{1, 0, 1, 32'h1001_0008, 32'h1,         0, 32'h0, 0});
    vecs.push_back('{1, 1, 0, 32'h1001_0008, 32'h0,         1, 32'h1, 0});
    vecs.push_back('{0, 1, 0, 32'h1001_0004, 32'h0,         1, 32'h0, 0});
    vecs.push_back('{1, 0, 1, 32'h1001_0000, 32'hCAFE_F00D, 0, 32'h0, 0});
    vecs.push_back('{1, 1, 0, 32'h0000_0000, 32'h0,         1, 32'h0, 0});
    vecs.push_back('{1, 1, 0, A_ERR,         32'h0,         1, 32'h1, 1});
    vecs.push_back('{1, 0, 1, 32'h1001_0002, 32'h1234_5678, 0, 32'h0, 1});
    vecs.push_back('{1, 1, 0, 32'h1001_0000, 32'h0,         1, 32'hCAFE_F00D, 1});
    vecs.push_back('{1, 1, 0, A_ERR,         32'h0,         1, 32'h3, 1});
    vecs.push_back('{1, 1, 0, 32'h1001_0005, 32'h0,         1, 32'h0, 1});
    vecs.push_back('{1, 0, 1, A_ERR,         32'h3,         0, 32'h0, 1});
    vecs.push_back('{1, 1, 0, A_ERR,         32'h0,         1, 32'h0, 0});
    vecs.push_back('{1, 1, 0, A_TXD,         32'h0,         1, 32'h0, 0});
    vecs.push_back('{1, 0, 1, A_STAT,        32'hFFFF_FFFF, 0, 32'h0, 0});
    vecs.push_back('{1, 1, 0, A_STAT,        32'h0,         1, 32'h1, 0});
    vecs.push_back('{1, 1, 1, 32'h1001_0008, 32'h55,        1, 32'h1, 0});
    vecs.push_back('{1, 1, 0, 32'h1001_0008, 32'h0,         1, 32'h55, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      cyc(vecs[i].cs, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, v);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), v, vecs[i].exp_rd);
    end

    // FIFO fill and overflow with the sink stalled
    rdy_lvl = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TXD, 32'h41 + 32'(i));
    rd_chk("stat_full", A_STAT, 32'h82);
    wr(A_TXD, 32'h49);
    rd_chk("err_overflow", A_ERR, 32'h4);
    chk("err_pin_overflow", 32'(err), 32'd1);
    rdy_lvl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'd1);
      chk("drain_data", 32'(tx_data), 32'h41 + 32'(i));
      idle();
    end
    chk("drain_empty", 32'(tx_valid), 32'd0);
    wr(A_ERR, 32'h7);

    // Push while full with a simultaneous pop
    rdy_lvl = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TXD, 32'h61 + 32'(i));
    cyc(1'b1, 1'b0, 1'b1, A_TXD, 32'h5A, 1'b1, v);
    rd_chk("full_pushpop_err", A_ERR, 32'h0);
    rd_chk("full_pushpop_stat", A_STAT, 32'h82);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h62 + 8'(i);
    drain_exp[7] = 8'h5A;
    rdy_lvl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("pp_drain_data", 32'(tx_data), 32'(drain_exp[i]));
      idle();
    end
    chk("pp_drain_empty", 32'(tx_valid), 32'd0);

    // Reset asserted mid-operation
    rdy_lvl = 1'b0;
    wr(A_TXD, 32'hA1);
    wr(A_TXD, 32'hA2);
    wr(A_TXD, 32'hA3);
    chk("pre_reset_valid", 32'(tx_valid), 32'd1);
    DM_cs = 1'b0; DM_r = 1'b0; DM_w = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_reset_valid", 32'(tx_valid), 32'd0);
    chk("async_reset_data", 32'(tx_data), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd_chk("post_reset_cnt0", A_CNT, 32'd0);
    rd_chk("post_reset_cnt1", A_CNT, 32'd1);
    rd_chk("post_reset_stat", A_STAT, 32'h1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      bit          cs, r, w;
      logic [31:0] a, d;
      int          idx;
      cs = 1'b1; r = 1'b0; w = 1'b0;
      d = $urandom;
      idx = ($urandom_range(0, 7) == 0) ? int'(RAM_WORDS) - 1 : int'($urandom_range(0, 15));
      a = RAM_BASE + 32'(4 * idx);
      case ($urandom_range(0, 9))
        0, 1, 2: w = 1'b1;
        3, 4: begin r = 1'b1; w = 1'($urandom_range(0, 1)); end
        5: begin a = A_TXD; w = 1'b1; end
        6: begin a = ($urandom_range(0, 1) == 0) ? A_STAT : A_CNT; r = 1'b1; end
        7: begin
          a = A_ERR;
          if ($urandom_range(0, 1) == 0) r = 1'b1;
          else begin w = 1'b1; d = 32'($urandom_range(0, 7)); end
          if ($urandom_range(0, 15) == 0) begin a = A_CNT; w = 1'b1; r = 1'b0; d = $urandom; end
        end
        8: begin
          case ($urandom_range(0, 3))
            0: a = RAM_BASE + 32'(4 * RAM_WORDS);
            1: a = RAM_BASE - 32'd4;
            2: a = MMIO_BASE + 32'd16;
            default: a = 32'h2000_0000;
          endcase
          r = 1'($urandom_range(0, 1));
          w = !r;
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            a = a + 32'($urandom_range(1, 3));
            r = 1'($urandom_range(0, 1));
            w = !r;
          end else begin
            cs = 1'b0; r = 1'b1; w = 1'($urandom_range(0, 1));
          end
        end
      endcase
      rdy_lvl = 1'($urandom_range(0, 1));
      cyc(cs, r, w, a, d, rdy_lvl, v);
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
